// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt arbiter.
// Contents: arbiter FSM state encoding, default 6502 source masks, and the id-width helper.
// 6502 mapping: 0 = RES (level, maskable), 1 = NMI (edge, non-maskable), 2 = IRQ (level, maskable).
package intc_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  localparam logic [2:0] DefEdgeMask = 3'b010;
  localparam logic [2:0] DefNmiMask  = 3'b010;

  // Width of a source id; never below one bit so a single source still has a usable port.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// One interrupt channel front end: synchroniser chain plus edge-history flop.
// Ports:
//   clk_i      - clock (phi1)
//   rst_i      - asynchronous active-high reset, forces all flops to 1 (line inactive)
//   src_l_i    - raw active-low interrupt line
//   sync_low_o - synchronised line, active-high
//   fall_o     - one-cycle strobe when the synchronised line has just gone active
module int_sync_edge
  import intc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_l_i,
  output logic sync_low_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  // Holds the previous last-stage level in pin polarity (1 = inactive), so reset value 1
  // means "previously inactive" and prevLow is its inverse.
  logic prev_d, prev_q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = src_l_i;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_low_o = ~sync_q[SYNC_STAGES-1];
  assign fall_o     = sync_low_o & prev_q;

endmodule

// File: rtl/interrupt_arbiter.sv
// Parametrised interrupt arbiter: synchronises NUM_SRC active-low sources, captures each as
// edge (sticky) or level pending, masks with intEn (NMI_MASK sources bypass the mask) and
// presents one fixed-priority request (index 0 highest) that is held until acknowledged.
// Ports:
//   phi1      - clock
//   rstAll    - asynchronous active-high reset
//   srcIn_L   - raw active-low interrupt lines
//   intEn     - per-source enable
//   ackValid  - acknowledge strobe, ackId = id being acknowledged
//   reqValid  - request presented, reqId / reqOneHot identify the source
//   pending   - raw pending vector before masking
//   ackErr    - one-cycle pulse on a mismatched or spurious acknowledge
module interrupt_arbiter
  import intc_pkg::*;
#(
  parameter int unsigned         NUM_SRC     = 3,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0]  EDGE_MASK   = DefEdgeMask,
  parameter logic [NUM_SRC-1:0]  NMI_MASK    = DefNmiMask,
  parameter int unsigned         ID_W        = id_width(NUM_SRC)
) (
  input  logic               phi1,
  input  logic               rstAll,
  input  logic [NUM_SRC-1:0] srcIn_L,
  input  logic [NUM_SRC-1:0] intEn,
  input  logic               ackValid,
  input  logic [ID_W-1:0]    ackId,
  output logic               reqValid,
  output logic [ID_W-1:0]    reqId,
  output logic [NUM_SRC-1:0] reqOneHot,
  output logic [NUM_SRC-1:0] pending,
  output logic               ackErr
);

  logic [NUM_SRC-1:0] sync_low, fall, elig;
  logic [NUM_SRC-1:0] pending_d, pending_q;
  logic [NUM_SRC-1:0] req_onehot_d, req_onehot_q;
  logic [ID_W-1:0]    req_id_d, req_id_q, pri_id;
  logic               req_valid_d, req_valid_q;
  logic               ack_err_d, ack_err_q;
  logic               pri_found, ack_hit;
  arb_state_e         state_d, state_q;

  for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_chan
    int_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i     (phi1),
      .rst_i     (rstAll),
      .src_l_i   (srcIn_L[g]),
      .sync_low_o(sync_low[g]),
      .fall_o    (fall[g])
    );
  end

  assign elig    = pending_q & (intEn | NMI_MASK);
  assign ack_hit = (state_q == StGrant) && ackValid && (ackId == req_id_q);

  // Fixed priority: scan downwards so the lowest eligible index is the last one written.
  always_comb begin
    pri_found = 1'b0;
    pri_id    = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pri_found = 1'b1;
        pri_id    = ID_W'(i);
      end
    end
  end

  // Edge sources are sticky until a matching ack; a new edge in the ack cycle wins.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (EDGE_MASK[i]) begin
        pending_d[i] = fall[i] | (pending_q[i] & ~(ack_hit && (req_id_q == ID_W'(i))));
      end else begin
        pending_d[i] = sync_low[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_id_d    = req_id_q;
    ack_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ackValid) ack_err_d = 1'b1;
        if (pri_found) begin
          state_d     = StGrant;
          req_valid_d = 1'b1;
          req_id_d    = pri_id;
        end
      end
      StGrant: begin
        // No pre-emption: only an ack or loss of eligibility ends the grant.
        if (ack_hit) begin
          state_d     = StIdle;
          req_valid_d = 1'b0;
        end else begin
          if (ackValid) ack_err_d = 1'b1;
          if (!elig[req_id_q]) begin
            state_d     = StIdle;
            req_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        req_valid_d = 1'b0;
      end
    endcase
    req_onehot_d = '0;
    if (req_valid_d) req_onehot_d[req_id_d] = 1'b1;
  end

  always_ff @(posedge phi1 or posedge rstAll) begin
    if (rstAll) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      req_valid_q  <= 1'b0;
      req_id_q     <= '0;
      req_onehot_q <= '0;
      ack_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      req_valid_q  <= req_valid_d;
      req_id_q     <= req_id_d;
      req_onehot_q <= req_onehot_d;
      ack_err_q    <= ack_err_d;
    end
  end

  assign reqValid  = req_valid_q;
  assign reqId     = req_id_q;
  assign reqOneHot = req_onehot_q;
  assign pending   = pending_q;
  assign ackErr    = ack_err_q;

endmodule

// File: doc/interrupt_arbiter.md
Name: interrupt_arbiter

Overview:
- Parametrised successor to the fixed three-line interrupt latch and control pair.
- Synchronises N active-low interrupt sources and captures each as edge- or level-type pending.
- Applies per-source enable masks (with non-maskable sources) and presents a single fixed-priority request to the control FSM.
- The request is held until a matching acknowledge clears it.
- Sits between the external pins and the random-control FSM, clocked on phi1.

Parameters:
- NUM_SRC, 3: number of interrupt sources. Index 0 has highest priority.
- SYNC_STAGES, 2: synchroniser flops per source. Minimum 1.
- EDGE_MASK, 3'b010: bit i = 1 makes source i falling-edge captured (sticky); 0 makes it level-sensitive.
- NMI_MASK, 3'b010: bit i = 1 makes source i ignore intEn[i].
- ID_W, clog2(NUM_SRC) (minimum 1): width of the source id.

Ports:
- phi1, in, 1: clock. All state updates on posedge.
- rstAll, in, 1: asynchronous active-high reset.
- srcIn_L, in, NUM_SRC: raw active-low interrupt lines.
- intEn, in, NUM_SRC: per-source enable. 1 = enabled.
- ackValid, in, 1: FSM acknowledges the current request.
- ackId, in, ID_W: id being acknowledged.
- reqValid, out, 1: a request is presented.
- reqId, out, ID_W: id of the presented source.
- reqOneHot, out, NUM_SRC: one-hot form of reqId. All zero when reqValid = 0.
- pending, out, NUM_SRC: raw pending vector, before masking.
- ackErr, out, 1: one-cycle pulse on a mismatched or spurious ack.

Behaviour:
- **Reset.** rstAll high asynchronously forces:
  - synchroniser flops and edge-history flops to 1 (inactive);
  - pending = 0, reqValid = 0, reqId = 0, reqOneHot = 0, ackErr = 0;
  - FSM to IDLE.
- **Reset mid-grant.** Asserting rstAll during GRANT drops the request immediately, with no ack needed.
- **Synchronisation.** Each line passes through SYNC_STAGES flops. syncLow[i] = inverted last stage.
- **Edge source** (EDGE_MASK[i] = 1):
  - fall[i] = syncLow[i] & ~prevLow[i]. prevLow is registered each cycle.
  - pending[i] is set at the posedge where fall[i] = 1.
  - pending[i] is cleared only by a matching ack.
  - Set wins over clear in the same cycle.
- **Level source** (EDGE_MASK[i] = 0): pending[i] = registered syncLow[i]. Ack does not clear it.
- **Eligibility.** elig = pending & (intEn | NMI_MASK).
- **FSM, 2 states, registered outputs.**
  - IDLE: if elig ≠ 0, latch reqId = lowest set index, set reqValid = 1, go to GRANT. Otherwise stay.
  - GRANT: reqId is held stable. A higher-priority source becoming eligible does NOT pre-empt.
  - GRANT, ackValid & ackId == reqId: clear pending[reqId] if it is an edge source, set reqValid = 0, go to IDLE. The next grant comes no earlier than the following cycle, giving a 1-cycle gap.
  - GRANT, ackValid & ackId ≠ reqId: ignore the ack, pulse ackErr, stay in GRANT.
  - GRANT, elig[reqId] drops (masked, or level released): withdraw. Set reqValid = 0, go to IDLE, pending unchanged.
  - GRANT, ack and withdraw in the same cycle: the ack takes effect.
  - IDLE, ackValid: pulse ackErr, no state change.
- **Latency.**
  - Edge source, falling edge first sampled at posedge k: pending set at k+SYNC_STAGES, reqValid high at k+SYNC_STAGES+1.
  - Level source has the same latency.
- **Masked pending.** An edge event arriving while masked stays pending and is granted once unmasked.
- **Repeated edges.** A second falling edge before ack does not queue. Pending is a single bit.

Decomposition:
- **Shared package intc_pkg:**
  - FSM state encoding (IDLE, GRANT);
  - default EDGE_MASK and NMI_MASK constants for the 6502 mapping: 0 = RES level, 1 = NMI edge/non-maskable, 2 = IRQ level/maskable;
  - ID width helper function.
- **Sub-module int_sync_edge:** one channel. Covers the synchroniser chain, prevLow flop and fall/syncLow outputs, parametrised by SYNC_STAGES. Instantiate it NUM_SRC times with a generate loop.
- The arbiter FSM and priority encoder stay in the top module.

Test Plan:
1. **Reset values.** rstAll pulse mid-GRANT -> reqValid, pending and reqOneHot = 0 immediately, without waiting for a clock edge.
2. **Edge capture latency.** Defaults, srcIn_L = 3'b101 (NMI low) held from posedge k -> pending = 3'b010 at k+2, reqValid = 1 with reqId = 1 at k+3. Ack with id 1 -> reqValid = 0 next cycle, pending = 0 even though the line is still low.
3. **Priority, no pre-emption.** IRQ (2) granted, then RES (0) asserted -> reqId stays 2 until ack. One cycle after the ack, reqId = 0.
4. **Masking.** intEn[2] = 0 with IRQ low -> no request.
   - Unmask -> reqId = 2 one cycle later.
   - Mask during GRANT -> withdrawn, pending[2] still 1.
   - NMI with intEn = 0 -> still granted.
5. **Ack errors.** ackId = 0 while reqId = 1 -> ackErr pulses 1 cycle, request held. Ack while IDLE -> ackErr pulses.
6. **Parametrised config.** NUM_SRC = 8, EDGE_MASK = 8'hFF, simultaneous falling edges on 3 and 6 -> grant 3. Ack in the same cycle as a new edge on 3 -> pending[3] stays 1 and is re-granted after a 1-cycle gap.
